// File: rtl/bk_irq_busctl.sv
// bk_irq_busctl: bus-cycle controller for a CSR register window plus vectored interrupt arbitration.
//   clk, reset_n                 clock, asynchronous active-low reset
//   ce                           clock enable; all state advances only on enabled edges
//   sync_i/din_i/dout_i/wtbt_i   CPU bus strobes, byte-op flag
//   iako_i                       interrupt acknowledge (sampled at SYNC rise)
//   addr_i/data_i                CPU address and write data
//   psw_pri_i                    CPU priority; interrupts only requested at priority 0
//   ext_rply_i                   reply from external memory (stops the timeout)
//   irq_req_i/irq_vec_i          per-channel request levels and 9-bit vectors
//   data_o                       CSR read data or acknowledged vector, 0 otherwise
//   reg_hit_o                    address falls in the 128-byte register window
//   rply_o/error_o               bus reply, one-ce bus-error pulse
//   virq_o/irq_ack_o             vectored IRQ request, per-channel acknowledge pulses
module bk_irq_busctl #(
  parameter int          NCHAN    = 2,
  parameter int          WAIT     = 0,
  parameter int          TIMEOUT  = 63,
  parameter logic [15:0] REG_BASE = 16'o177600,
  parameter logic [6:0]  CSR_OFS  = 7'o060
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ce,
  input  logic                 sync_i,
  input  logic                 din_i,
  input  logic                 dout_i,
  input  logic                 wtbt_i,
  input  logic                 iako_i,
  input  logic [15:0]          addr_i,
  input  logic [15:0]          data_i,
  input  logic [2:0]           psw_pri_i,
  input  logic                 ext_rply_i,
  input  logic [NCHAN-1:0]     irq_req_i,
  input  logic [9*NCHAN-1:0]   irq_vec_i,
  output logic [15:0]          data_o,
  output logic                 reg_hit_o,
  output logic                 rply_o,
  output logic                 error_o,
  output logic                 virq_o,
  output logic [NCHAN-1:0]     irq_ack_o
);
  localparam int IW = NCHAN > 1 ? $clog2(NCHAN) : 1;
  typedef enum logic [1:0] {IDLE = 2'd0, WAITST = 2'd1, REPLY = 2'd2, HOLD = 2'd3} st_t;
  st_t             st_q;
  logic [2:0]      wcnt_q;
  logic [7:0]      tmo_q;
  logic            run_q, sync_q, err_q, virq_q, is_ack_q, win_v_q;
  logic [NCHAN-1:0] m_q, ackp_q, pend;
  logic [IW-1:0]   ch_q, win_q, csr_ch, win_c;
  logic            csr_hit, rise, unused_ok;
  logic [8:0]      vec_w;
  assign reg_hit_o = addr_i[15:7] == REG_BASE[15:7];
  assign pend = irq_req_i & ~m_q;
  assign rise = sync_i & ~sync_q;
  assign unused_ok = ^{data_i[15:7], data_i[5:0]};
  always_comb begin
    csr_hit = 1'b0;
    csr_ch = '0;
    win_c = '0;
    // CSRs are word registers, so address bit 0 is ignored in the decode
    for (int i = 0; i < NCHAN; i++)
      if (reg_hit_o && addr_i[6:1] == 6'((CSR_OFS + 7'(4 * i)) >> 1)) begin
        csr_hit = 1'b1;
        csr_ch = IW'(i);
      end
    // descending scan so the lowest pending index wins
    for (int i = NCHAN - 1; i >= 0; i--)
      if (pend[i]) win_c = IW'(i);
  end
  assign vec_w = irq_vec_i[9 * win_q +: 9];
  assign data_o = st_q == IDLE ? '0 :
                  is_ack_q ? (win_v_q ? {7'b0, vec_w} : '0) :
                  {8'b0, irq_req_i[ch_q], m_q[ch_q], 6'b0};
  assign rply_o = st_q[1];
  assign error_o = err_q;
  assign virq_o = virq_q;
  assign irq_ack_o = ackp_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q <= IDLE;
      wcnt_q <= '0;
      tmo_q <= '0;
      run_q <= 1'b0;
      sync_q <= 1'b0;
      err_q <= 1'b0;
      virq_q <= 1'b0;
      is_ack_q <= 1'b0;
      win_v_q <= 1'b0;
      m_q <= '0;
      ackp_q <= '0;
      ch_q <= '0;
      win_q <= '0;
    end else if (ce) begin
      sync_q <= sync_i;
      virq_q <= |pend && psw_pri_i == 3'd0;
      ackp_q <= '0;
      err_q <= 1'b0;
      if (rise) begin
        run_q <= 1'b1;
        tmo_q <= '0;
      end else if (!sync_i || rply_o || ext_rply_i) begin
        run_q <= 1'b0;
        tmo_q <= '0;
      end else if (run_q) begin
        tmo_q <= tmo_q + 8'd1;
        if (tmo_q == 8'(TIMEOUT - 1)) begin
          err_q <= 1'b1;
          run_q <= 1'b0;
        end
      end
      case (st_q)
        IDLE:
          if (rise && (csr_hit || iako_i)) begin
            st_q <= WAITST;
            wcnt_q <= 3'(WAIT);
            is_ack_q <= iako_i;
            ch_q <= csr_ch;
            win_q <= win_c;
            win_v_q <= |pend;
          end
        WAITST:
          if (!sync_i) st_q <= IDLE;
          else if (wcnt_q == 3'd0) begin
            st_q <= REPLY;
            if (is_ack_q && win_v_q) ackp_q[win_q] <= 1'b1;
          end else wcnt_q <= wcnt_q - 3'd1;
        REPLY:
          if (!sync_i) st_q <= IDLE;
          else if (din_i || dout_i) begin
            st_q <= HOLD;
            // odd-byte writes miss the mask bit, which lives in the low byte
            if (dout_i && !is_ack_q && !(wtbt_i && addr_i[0])) m_q[ch_q] <= data_i[6];
          end
        default:
          if (!sync_i) st_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bk_irq_busctl.sv
// tb_bk_irq_busctl: directed scoreboard bench for bk_irq_busctl (NCHAN=2, WAIT=2, TIMEOUT=63).
module tb_bk_irq_busctl;
  logic clk = 1'b0;
  logic reset_n, ce, sync_i, din_i, dout_i, wtbt_i, iako_i, ext_rply_i;
  logic [15:0] addr_i, data_i, data_o;
  logic [2:0] psw_pri_i;
  logic [1:0] irq_req_i, irq_ack_o;
  logic [17:0] irq_vec_i;
  logic reg_hit_o, rply_o, error_o, virq_o;
  int checks = 0, errors = 0, since = 0, n_err = 0;
  typedef struct {string nm; bit is_err; logic [15:0] data; logic [1:0] ack;} exp_t;
  exp_t q[$];
  bk_irq_busctl #(.NCHAN(2), .WAIT(2), .TIMEOUT(63)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .sync_i(sync_i), .din_i(din_i), .dout_i(dout_i),
    .wtbt_i(wtbt_i), .iako_i(iako_i), .addr_i(addr_i), .data_i(data_i), .psw_pri_i(psw_pri_i),
    .ext_rply_i(ext_rply_i), .irq_req_i(irq_req_i), .irq_vec_i(irq_vec_i), .data_o(data_o),
    .reg_hit_o(reg_hit_o), .rply_o(rply_o), .error_o(error_o), .virq_o(virq_o), .irq_ack_o(irq_ack_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0o expected %0o", nm, act, exp);
    end
  endtask
  task automatic fail(input string nm, input string msg);
    checks++;
    errors++;
    $display("FAIL %s: %s", nm, msg);
  endtask
  task automatic push(input string nm, input bit e, input logic [15:0] d, input logic [1:0] a);
    exp_t x;
    x.nm = nm;
    x.is_err = e;
    x.data = d;
    x.ack = a;
    q.push_back(x);
  endtask
  // monitor: ce counted from the SYNC-rise edge; pops an expectation on every reply/error
  initial begin
    logic prply, perr, psync;
    exp_t e;
    prply = 1'b0;
    perr = 1'b0;
    psync = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      since = (sync_i && !psync) ? -1 : since + 1;
      if (rply_o && !prply) begin
        if (q.size() == 0) fail("unexpected_rply", "got rply_o=1, expected no reply");
        else begin
          e = q.pop_front();
          chk({e.nm, "_kind_err"}, 32'(e.is_err), 32'(1'b0));
          chk({e.nm, "_data"}, 32'(data_o), 32'(e.data));
          chk({e.nm, "_lat"}, 32'(since), 32'd3);
          chk({e.nm, "_ack"}, 32'(irq_ack_o), 32'(e.ack));
        end
      end else if (irq_ack_o != 2'b00) chk("stray_ack", 32'(irq_ack_o), 32'd0);
      if (error_o && perr) fail("error_width", "got error_o high for 2 ce, expected 1");
      else if (error_o) begin
        n_err++;
        if (q.size() == 0) fail("unexpected_error", "got error_o=1, expected no error");
        else begin
          e = q.pop_front();
          chk({e.nm, "_kind_err"}, 32'(e.is_err), 32'(1'b1));
          chk({e.nm, "_lat"}, 32'(since), 32'd63);
        end
      end
      prply = rply_o;
      perr = error_o;
      psync = sync_i;
    end
  end
  task automatic bus(input logic [15:0] a, input logic [15:0] d, input bit wr, input bit bt, input bit ak);
    int n;
    @(negedge clk);
    addr_i = a;
    data_i = d;
    wtbt_i = bt;
    iako_i = ak;
    sync_i = 1'b1;
    @(negedge clk);
    din_i = !wr;
    dout_i = wr;
    n = 0;
    while (!rply_o && !error_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail("bus_no_response", $sformatf("addr %0o got no rply_o/error_o, expected one", a));
    @(negedge clk);
    sync_i = 1'b0;
    din_i = 1'b0;
    dout_i = 1'b0;
    iako_i = 1'b0;
    wtbt_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end
  initial begin
    int n, e0;
    reset_n = 1'b0; ce = 1'b1; sync_i = 1'b0; din_i = 1'b0; dout_i = 1'b0; wtbt_i = 1'b0;
    iako_i = 1'b0; ext_rply_i = 1'b0; addr_i = '0; data_i = '0; psw_pri_i = 3'd0;
    irq_req_i = 2'b01; irq_vec_i = {9'o274, 9'o060};
    repeat (3) @(negedge clk);
    chk("rst_rply", 32'(rply_o), 0);
    chk("rst_error", 32'(error_o), 0);
    chk("rst_virq", 32'(virq_o), 0);
    chk("rst_ack", 32'(irq_ack_o), 0);
    chk("rst_data", 32'(data_o), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("virq_req0", 32'(virq_o), 1);
    addr_i = 16'o177600; #1 chk("hit_base", 32'(reg_hit_o), 1);
    addr_i = 16'o177577; #1 chk("hit_below", 32'(reg_hit_o), 0);
    addr_i = 16'o177777; #1 chk("hit_top", 32'(reg_hit_o), 1);
    addr_i = 16'o077600; #1 chk("hit_msb", 32'(reg_hit_o), 0);
    addr_i = 16'o0;
    chk("idle_data", 32'(data_o), 0);
    push("rd0", 0, 16'o000200, 2'b00);   bus(16'o177660, 16'o0, 0, 0, 0);
    push("wr0_set", 0, 16'o000200, 2'b00); bus(16'o177660, 16'o000100, 1, 0, 0);
    chk("virq_masked", 32'(virq_o), 0);
    chk("post_cycle_data", 32'(data_o), 0);
    push("rd0_m", 0, 16'o000300, 2'b00); bus(16'o177660, 16'o0, 0, 0, 0);
    push("wr0_odd", 0, 16'o000300, 2'b00); bus(16'o177661, 16'o0, 1, 1, 0);
    push("rd0_odd", 0, 16'o000300, 2'b00); bus(16'o177660, 16'o0, 0, 0, 0);
    push("wr0_clr", 0, 16'o000300, 2'b00); bus(16'o177660, 16'o0, 1, 0, 0);
    chk("virq_unmasked", 32'(virq_o), 1);
    irq_req_i = 2'b11;
    push("rd1", 0, 16'o000200, 2'b00);   bus(16'o177664, 16'o0, 0, 0, 0);
    push("iack_both", 0, 16'o000060, 2'b01); bus(16'o0, 16'o0, 0, 0, 1);
    push("wr0_set2", 0, 16'o000200, 2'b00); bus(16'o177660, 16'o000100, 1, 0, 0);
    push("iack_ch1", 0, 16'o000274, 2'b10); bus(16'o0, 16'o0, 0, 0, 1);
    push("wr0_clr2", 0, 16'o000300, 2'b00); bus(16'o177660, 16'o0, 1, 0, 0);
    irq_req_i = 2'b00;
    push("iack_none", 0, 16'o000000, 2'b00); bus(16'o0, 16'o0, 0, 0, 1);
    chk("virq_noreq", 32'(virq_o), 0);
    irq_req_i = 2'b01;
    psw_pri_i = 3'd7;
    repeat (2) @(negedge clk);
    chk("virq_pri7", 32'(virq_o), 0);
    psw_pri_i = 3'd0;
    repeat (2) @(negedge clk);
    chk("virq_pri0", 32'(virq_o), 1);
    ce = 1'b0;
    psw_pri_i = 3'd7;
    repeat (4) @(negedge clk);
    chk("ce_hold_virq", 32'(virq_o), 1);
    ce = 1'b1;
    repeat (2) @(negedge clk);
    chk("ce_resume_virq", 32'(virq_o), 0);
    psw_pri_i = 3'd0;
    push("tmo_177700", 1, 16'o0, 2'b00); bus(16'o177700, 16'o0, 0, 0, 0);
    push("tmo_177670", 1, 16'o0, 2'b00); bus(16'o177670, 16'o0, 0, 0, 0);
    e0 = n_err;
    @(negedge clk);
    addr_i = 16'o001000;
    sync_i = 1'b1;
    @(negedge clk);
    din_i = 1'b1;
    repeat (4) @(negedge clk);
    ext_rply_i = 1'b1;
    @(negedge clk);
    sync_i = 1'b0; din_i = 1'b0; ext_rply_i = 1'b0;
    repeat (80) @(negedge clk);
    chk("ram_no_error", 32'(n_err), 32'(e0));
    @(negedge clk);
    addr_i = 16'o177660;
    data_i = 16'o000100;
    sync_i = 1'b1;
    @(negedge clk);
    dout_i = 1'b1;
    @(negedge clk);
    sync_i = 1'b0;
    dout_i = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_rply", 32'(rply_o), 0);
    push("rd0_abort", 0, 16'o000200, 2'b00); bus(16'o177660, 16'o0, 0, 0, 0);
    push("rd0_midrst", 0, 16'o000200, 2'b00);
    @(negedge clk);
    addr_i = 16'o177660;
    sync_i = 1'b1;
    @(negedge clk);
    din_i = 1'b1;
    n = 0;
    while (!rply_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) fail("midrst_no_rply", "got no rply_o, expected rply_o");
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_rply", 32'(rply_o), 0);
    chk("midrst_ack", 32'(irq_ack_o), 0);
    chk("midrst_data", 32'(data_o), 0);
    @(negedge clk);
    sync_i = 1'b0;
    din_i = 1'b0;
    reset_n = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("queue_empty", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bk_irq_busctl.md
BK_IRQ_BUSCTL -- requirements
Module: bk_irq_busctl

Interface
REQ-001 SHALL have parameter NCHAN, default 2: interrupt channels, 1..8.
REQ-002 SHALL have parameter WAIT, default 0: extra ce cycles before register-space reply, 0..7.
REQ-003 SHALL have parameter TIMEOUT, default 63: ce cycles from SYNC rise to bus error, 8..255.
REQ-004 SHALL have parameter REG_BASE, default 16'o177600: 128-byte register window base.
REQ-005 SHALL have parameter CSR_OFS, default 7'o060: offset of channel-0 CSR; channel i CSR at CSR_OFS+4*i.
REQ-006 SHALL have ports: clk in 1 system clock; reset_n in 1 asynchronous active-low reset.
REQ-007 SHALL have ports: ce in 1 clock enable; sync_i in 1 CPU SYNC; din_i in 1 CPU DIN; dout_i in 1 CPU DOUT; wtbt_i in 1 byte op; iako_i in 1 interrupt acknowledge.
REQ-008 SHALL have ports: addr_i in 16 CPU address; data_i in 16 CPU write data; psw_pri_i in 3 CPU priority.
REQ-009 SHALL have ports: ext_rply_i in 1 memory reply; irq_req_i in NCHAN request levels; irq_vec_i in 9*NCHAN vectors, channel i in bits [9i+8:9i].
REQ-010 SHALL have ports: data_o out 16 read/vector data; reg_hit_o out 1 register-window decode; rply_o out 1 reply; error_o out 1 bus error; virq_o out 1 vectored IRQ; irq_ack_o out NCHAN acknowledge pulses.

Function
REQ-011 SHALL update all state only on clk rising edges with ce=1; reset is the only exception.
REQ-012 SHALL drive reg_hit_o combinationally: addr_i[15:7]==REG_BASE[15:7].
REQ-013 SHALL keep per-channel mask bit m[i], 1 = disabled; pending p[i] = irq_req_i[i] & ~m[i].
REQ-014 SHALL drive virq_o = 1 when any p[i]=1 and psw_pri_i==0, registered once per ce.
REQ-015 SHALL sample sync_i into sync_q every ce; SYNC rise = sync_i & ~sync_q.
REQ-016 SHALL run FSM IDLE->WAITST->REPLY->HOLD->IDLE for cycles with a CSR hit, or with iako_i=1 at SYNC rise.
REQ-017 SHALL go IDLE->WAITST on SYNC rise, load wait counter with WAIT; WAITST->REPLY when counter is 0, else decrement.
REQ-018 SHALL assert rply_o in REPLY and HOLD; REPLY->HOLD when din_i|dout_i; HOLD->IDLE when sync_i=0, rply_o low next ce.
REQ-019 SHALL, for a CSR read, drive data_o = {8'0, irq_req_i[i], m[i], 6'0}.
REQ-020 SHALL, for a CSR write (dout_i in REPLY), set m[i] <= data_i[6] once per bus cycle; odd-byte write (wtbt_i & addr_i[0]) SHALL leave m[i] unchanged.
REQ-021 SHALL, on acknowledge, latch the winner at SYNC rise: lowest-index p[i]; data_o = {7'0, vec[i]}; pulse irq_ack_o[i] for one ce in REPLY.
REQ-022 SHALL return data_o = 0 with no irq_ack_o pulse if no p[i] is set at acknowledge.
REQ-023 SHALL NOT reply to register-window addresses that are not CSRs; those SHALL time out.
REQ-024 SHALL run a timeout counter from SYNC rise, cleared by rply_o|ext_rply_i or sync_i=0.
REQ-025 SHALL pulse error_o for exactly one ce when the timeout counter reaches TIMEOUT.
REQ-026 SHALL drive data_o = 0 outside a register/acknowledge cycle.
REQ-027 SHALL handle SYNC dropping in WAITST or REPLY: return to IDLE next ce, no write, no ack pulse.
REQ-028 SHALL give write priority to data_i on an m[i] write when irq_req_i changes in the same ce; virq_o reflects the new mask next ce.

Reset
REQ-029 SHALL, while reset_n=0, force FSM=IDLE, counters=0, sync_q=0, m=all 0, rply_o=0, error_o=0, virq_o=0, irq_ack_o=0, data_o=0.
REQ-030 SHALL, if reset asserts mid-cycle, drop rply_o immediately with no residual write or ack.

Verification
REQ-031 WAIT=2: CSR 177660 read, irq_req_i[0]=1 -> rply_o rises 3 ce after SYNC rise, data_o=16'o000200.
REQ-032 Write 16'o000100 to 177660 -> m[0]=1, virq_o=0 next ce with irq_req_i[0]=1; odd-byte write of 16'o100 leaves m[0] unchanged.
REQ-033 NCHAN=2, both requesting, vec0=9'o060, vec1=9'o274, IAKO -> data_o=16'o060, irq_ack_o=2'b01 for one ce.
REQ-034 Read 177700 (unmapped) -> no rply_o; error_o one ce at TIMEOUT=63 ce after SYNC rise.
REQ-035 RAM cycle with ext_rply_i at ce 5 -> no error_o; psw_pri_i=7 with pending request -> virq_o=0.
